// File: rtl/decoder_sweep_unit.sv
// Registered N-to-2^N decoder with 138-style enables, minterm-OR function output
// and a built-in sweeper that captures F for every select code and checks it.
module decoder_sweep_unit #(
  parameter int                   N        = 3,
  parameter int                   HOLD     = 50,
  parameter logic [(1<<N)-1:0]    MINTERMS = 'b1001_0110
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N-1:0]        ext_sel,
  input  logic                g1,
  input  logic                g2a_n,
  input  logic                g2b_n,
  output logic [N-1:0]        sel,
  output logic [(1<<N)-1:0]   dec_n,
  output logic                f,
  output logic                busy,
  output logic                done,
  output logic [(1<<N)-1:0]   result,
  output logic                pass
);
  localparam int M  = 1 << N;
  localparam int CW = (HOLD > 2) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    sel_q, sel_d;
  logic [M-1:0]    dec_n_q, dec_n_d;
  logic            f_q, f_d;
  logic [M-1:0]    result_q, result_d;
  logic            pass_q, pass_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            en;

  always_comb begin
    en       = g1 & ~g2a_n & ~g2b_n;
    dec_n_d  = en ? ~(M'(1) << sel_q) : '1;
    f_d      = en & MINTERMS[sel_q];
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    pass_d   = pass_q;
    case (state_q)
      IDLE, DONE: begin
        sel_d = ext_sel;
        if (start) begin
          state_d  = SWEEP;
          sel_d    = '0;
          cnt_d    = '0;
          result_d = '0;
          pass_d   = 1'b0;
        end
      end
      SWEEP: begin
        if (cnt_q == CW'(HOLD - 1)) begin
          cnt_d           = '0;
          // f_q has settled for sel_q since HOLD >= 2
          result_d[sel_q] = f_q;
          if (sel_q != N'(M - 1)) begin
            sel_d = sel_q + 1'b1;
          end else begin
            state_d = DONE;
            pass_d  = (result_d == MINTERMS);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      dec_n_q  <= '1;
      f_q      <= 1'b0;
      result_q <= '0;
      pass_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      dec_n_q  <= dec_n_d;
      f_q      <= f_d;
      result_q <= result_d;
      pass_q   <= pass_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sel    = sel_q;
  assign dec_n  = dec_n_q;
  assign f      = f_q;
  assign busy   = (state_q == SWEEP);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign pass   = pass_q;
endmodule

// File: tb/tb_decoder_sweep_unit.sv
// Bench for decoder_sweep_unit: manual-mode vector table plus full sweeps with
// enable drop-outs, ignored/restart start pulses and a mid-sweep reset.
module tb_decoder_sweep_unit;
  localparam int N = 3;
  localparam int HOLD = 4;
  localparam logic [7:0] MT = 8'h96;

  logic clk = 1'b0;
  logic rst, start, g1, g2a_n, g2b_n;
  logic [N-1:0] ext_sel, sel;
  logic [7:0] dec_n, result;
  logic f, busy, done, pass;

  int n_tot = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  decoder_sweep_unit #(.N(N), .HOLD(HOLD), .MINTERMS(MT)) dut (
    .clk(clk), .rst(rst), .start(start), .ext_sel(ext_sel),
    .g1(g1), .g2a_n(g2a_n), .g2b_n(g2b_n),
    .sel(sel), .dec_n(dec_n), .f(f), .busy(busy), .done(done),
    .result(result), .pass(pass)
  );

  typedef struct {
    logic [2:0] sel;
    logic [7:0] dec_n;
    logic       f;
    logic       busy;
    logic       done;
    bit         has_dec;
  } out_t;

  typedef struct {
    logic [2:0] ext_sel;
    logic       g1, g2a_n, g2b_n;
    logic [2:0] sel;
    logic [7:0] dec_n;
    logic       f;
    bit         one_edge;
  } vec_t;

  out_t sb[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_cmp(input string tag);
    out_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_sel"}, 32'(sel), 32'(e.sel));
    check({tag, "_busy"}, 32'(busy), 32'(e.busy));
    check({tag, "_done"}, 32'(done), 32'(e.done));
    if (e.has_dec) begin
      check({tag, "_dec_n"}, 32'(dec_n), 32'(e.dec_n));
      check({tag, "_f"}, 32'(f), 32'(e.f));
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_sel"}, 32'(sel), 0);
    check({tag, "_dec_n"}, 32'(dec_n), 32'hFF);
    check({tag, "_f"}, 32'(f), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_result"}, 32'(result), 0);
    check({tag, "_pass"}, 32'(pass), 0);
  endtask

  // Sweep from IDLE/DONE; g1 is low for sweep cycles dlo..dhi; rst_at<32 aborts.
  task automatic run_sweep(input string tag, input logic [7:0] exp_res, input logic exp_pass,
                           input int dlo, input int dhi, input int rst_at);
    g1 = 1'b1; g2a_n = 1'b0; g2b_n = 1'b0;
    sb.push_back('{sel: 3'd0, dec_n: 8'h00, f: 1'b0, busy: 1'b1, done: 1'b0, has_dec: 1'b0});
    start = 1'b1;
    tick();
    start = 1'b0;
    pop_cmp({tag, "_c0"});
    check({tag, "_clr_result"}, 32'(result), 0);
    check({tag, "_clr_pass"}, 32'(pass), 0);
    for (int c = 0; c < 8 * HOLD; c++) begin
      g1 = !(c >= dlo && c <= dhi);
      ext_sel = 3'($urandom);
      start = (c == 6);
      if (c == rst_at) begin
        rst = 1'b1;
        sb.push_back('{sel: 3'd0, dec_n: 8'hFF, f: 1'b0, busy: 1'b0, done: 1'b0, has_dec: 1'b1});
        tick();
        rst = 1'b0; start = 1'b0; g1 = 1'b1;
        pop_cmp({tag, "_rst"});
        check_reset({tag, "_rst"});
        return;
      end
      if (c == 8 * HOLD - 1)
        sb.push_back('{sel: 3'd7, dec_n: 8'h00, f: 1'b0, busy: 1'b0, done: 1'b1, has_dec: 1'b0});
      else
        sb.push_back('{sel: 3'((c + 1) / HOLD), dec_n: 8'h00, f: 1'b0, busy: 1'b1, done: 1'b0, has_dec: 1'b0});
      tick();
      start = 1'b0;
      pop_cmp(tag);
    end
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_pass"}, 32'(pass), 32'(exp_pass));
    // DONE keeps result/pass while sel follows ext_sel again
    ext_sel = 3'd3;
    tick(); tick();
    check({tag, "_hold_sel"}, 32'(sel), 3);
    check({tag, "_hold_done"}, 32'(done), 1);
    check({tag, "_hold_result"}, 32'(result), 32'(exp_res));
    check({tag, "_hold_pass"}, 32'(pass), 32'(exp_pass));
  endtask

  vec_t vt[12];

  initial begin
    vt[0]  = '{3'd4, 1'b1, 1'b0, 1'b0, 3'd4, 8'hEF, 1'b1, 1'b0};
    vt[1]  = '{3'd5, 1'b1, 1'b0, 1'b0, 3'd5, 8'hDF, 1'b0, 1'b0};
    vt[2]  = '{3'd4, 1'b1, 1'b0, 1'b0, 3'd4, 8'hEF, 1'b1, 1'b0};
    vt[3]  = '{3'd4, 1'b1, 1'b1, 1'b0, 3'd4, 8'hFF, 1'b0, 1'b1};
    vt[4]  = '{3'd4, 1'b1, 1'b0, 1'b0, 3'd4, 8'hEF, 1'b1, 1'b1};
    vt[5]  = '{3'd4, 1'b0, 1'b0, 1'b0, 3'd4, 8'hFF, 1'b0, 1'b1};
    vt[6]  = '{3'd4, 1'b1, 1'b0, 1'b0, 3'd4, 8'hEF, 1'b1, 1'b1};
    vt[7]  = '{3'd4, 1'b1, 1'b0, 1'b1, 3'd4, 8'hFF, 1'b0, 1'b1};
    vt[8]  = '{3'd4, 1'b1, 1'b0, 1'b0, 3'd4, 8'hEF, 1'b1, 1'b1};
    vt[9]  = '{3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 8'hFE, 1'b0, 1'b0};
    vt[10] = '{3'd7, 1'b1, 1'b0, 1'b0, 3'd7, 8'h7F, 1'b1, 1'b0};
    vt[11] = '{3'd7, 1'b0, 1'b1, 1'b1, 3'd7, 8'hFF, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; ext_sel = '0; g1 = 1'b0; g2a_n = 1'b1; g2b_n = 1'b1;
    tick(); tick();
    check_reset("reset");
    rst = 1'b0;

    foreach (vt[i]) begin
      ext_sel = vt[i].ext_sel; g1 = vt[i].g1; g2a_n = vt[i].g2a_n; g2b_n = vt[i].g2b_n;
      sb.push_back('{sel: vt[i].sel, dec_n: vt[i].dec_n, f: vt[i].f, busy: 1'b0, done: 1'b0, has_dec: 1'b1});
      tick();
      check($sformatf("vec%0d_sel_1edge", i), 32'(sel), 32'(vt[i].sel));
      if (vt[i].one_edge) begin
        check($sformatf("vec%0d_dec_1edge", i), 32'(dec_n), 32'(vt[i].dec_n));
        check($sformatf("vec%0d_f_1edge", i), 32'(f), 32'(vt[i].f));
      end
      tick();
      pop_cmp($sformatf("vec%0d", i));
    end

    run_sweep("sweep_full", 8'h96, 1'b1, 100, 100, 100);
    run_sweep("sweep_g1off", 8'h92, 1'b0, 2 * HOLD, 4 * HOLD - 1, 100);
    run_sweep("sweep_rst", 8'h00, 1'b0, 100, 100, 10);
    run_sweep("sweep_after_rst", 8'h96, 1'b1, 100, 100, 100);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/decoder_sweep_unit.md
Name: decoder_sweep_unit

Overview:
Parametrised, registered N-to-2^N decoder with 74LS138-style enables (G1, /G2A, /G2B). It realises a boolean function F as the OR of selected decoder minterms, given by the MINTERMS mask. A built-in sweeper steps the select through all 2^N codes, holds each for HOLD cycles, captures F per code and flags pass/fail against MINTERMS. It is the on-board self-checking successor to the bench-driven 3-input decoder/function experiments.

Parameters:
N, 3, select width; decoder has 2^N outputs.
HOLD, 50, cycles each select code is held during a sweep; legal range 2..65535.
MINTERMS, 8'b1001_0110, 2^N-bit mask; bit k=1 puts minterm k in F.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  one-cycle pulse; begins a sweep from IDLE or DONE.
ext_sel  input  N  manual select code, used outside SWEEP.
g1  input  1  enable, active-high.
g2a_n  input  1  enable, active-low.
g2b_n  input  1  enable, active-low.
sel  output  N  registered current select code.
dec_n  output  2^N  registered one-hot-low decoder outputs.
f  output  1  registered function output.
busy  output  1  high while in SWEEP.
done  output  1  high while in DONE.
result  output  2^N  captured F per code; bit k holds F for sel=k.
pass  output  1  result==MINTERMS, valid while done=1.

Behaviour:
- Reset values: sel=0, dec_n=all ones, f=0, busy=0, done=0, result=0, pass=0, state=IDLE, hold counter=0.
- en = g1 & ~g2a_n & ~g2b_n, sampled each cycle.
- Decoder/function registers: every edge, dec_n <= en ? ~(1<<sel) : all ones, and f <= en & MINTERMS[sel], where sel is the current registered value. dec_n and f lag sel by one cycle. en changes reach dec_n and f at the next edge.
- States: IDLE, SWEEP, DONE. busy=(state==SWEEP); done=(state==DONE). Both are decoded from the registered state.
- IDLE and DONE:
  - sel <= ext_sel every cycle.
  - start=1: go to SWEEP, sel<=0, hold counter<=0, result<=0, pass<=0.
- SWEEP:
  - ext_sel is ignored and start is ignored.
  - The hold counter counts 0..HOLD-1.
  - When the counter reaches HOLD-1: result[sel] <= f, counter <= 0.
    - If sel < 2^N-1, sel <= sel+1.
    - Otherwise go to DONE, sel stays at 2^N-1, and pass <= ({f,result[2^N-2:0]}==MINTERMS), which includes the final capture.
  - HOLD>=2 guarantees that the captured f reflects the current sel.
- Sweep timing: busy is high for exactly 2^N*HOLD cycles. done rises on the edge after the last capture.
- A disabled decoder during any hold window yields f=0, so the captured bit is 0. The sweep does not pause.
- DONE holds result and pass until the next start or rst.
- rst has priority over everything, including mid-sweep: at the next edge all registers return to their reset values.
- No arithmetic overflow: the hold counter is ceil(log2(HOLD)) bits and sel wraps only via the state exit.

Test Plan:
(Parameters for all scenarios: N=3, HOLD=4, MINTERMS=8'h96.)
1. Assert rst 2 cycles, then release -> sel=0, dec_n=8'hFF, f=0, busy=0, done=0, result=0, pass=0.
2. IDLE, en active, ext_sel=4 -> sel=4 after 1 edge; after the 2nd edge dec_n=8'b1110_1111, f=1. Then ext_sel=5 -> dec_n=8'b1101_1111, f=0.
3. Hold ext_sel=4, set g2a_n=1 (also repeat with g1=0, and with g2b_n=1) -> dec_n=8'hFF and f=0 one edge later. Restore the enable -> dec_n=8'b1110_1111, f=1.
4. start pulse with en held active -> busy high for exactly 32 cycles, sel steps 0..7 every 4 cycles, then done=1, result=8'h96, pass=1. A start pulse during the sweep has no effect. A start pulse in DONE restarts with result cleared.
5. Sweep with g1=0 while sel is 2 and 3 -> result=8'h92, pass=0.
6. Assert rst for 1 cycle at sweep cycle 10 -> next edge shows all reset values with busy=0. A new start then completes with result=8'h96, pass=1.
